// File: rtl/qbus_pkg.sv
// Shared Qbus types and timing defaults for the register slave and the DMA master.
package qbus_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_WAITBUS, S_ADDR, S_ASYNC, S_DATA, S_WREPLY, S_WEND, S_DONE
  } qstate_e;

  localparam logic [8:0] IOPAGE_TOP = 9'o777;

  localparam int T_SETUP_DEF  = 4;
  localparam int T_HOLD_DEF   = 2;
  localparam int T_DESKEW_DEF = 2;
  localparam int TIMEOUT_DEF  = 1000;

  typedef struct packed {
    logic        write;
    logic        bmode;
    logic [21:0] addr;
    logic [15:0] wdata;
  } qcmd_t;

  function automatic logic is_iopage(input logic [21:0] a);
    return a[21:13] == IOPAGE_TOP;
  endfunction

endpackage

// File: rtl/qbus_dma_master_if.sv
// Command/response and Qbus pin bundle for the DMA master.
interface qbus_dma_master_if;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_byte;
  logic [21:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_error;
  logic [15:0] rsp_rdata;
  logic [21:0] BDALf_IN, BDALf_OUT, BDALf_OE;
  logic        Outbound;
  logic        BRPLYf, BDMGIf, BSYNCf, BINITf;
  logic        BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMRg, BSACKg, BDMGOg;

  modport master (
    input  cmd_valid, cmd_write, cmd_byte, cmd_addr, cmd_wdata,
           BDALf_IN, BRPLYf, BDMGIf, BSYNCf, BINITf,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
           BDALf_OUT, BDALf_OE, Outbound,
           BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMRg, BSACKg, BDMGOg
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_byte, cmd_addr, cmd_wdata,
           BDALf_IN, BRPLYf, BDMGIf, BSYNCf, BINITf,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
           BDALf_OUT, BDALf_OE, Outbound,
           BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMRg, BSACKg, BDMGOg
  );
endinterface

// File: rtl/qbus_sync.sv
// Parameterised 2-flop synchronizer; resets to the line's deasserted level.
module qbus_sync #(
  parameter int   W       = 1,
  parameter logic RST_VAL = 1'b1
) (
  input  logic         clock,
  input  logic         RSTN,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1, s2;

  always_ff @(posedge clock or negedge RSTN) begin
    if (!RSTN) begin
      s1 <= {W{RST_VAL}};
      s2 <= {W{RST_VAL}};
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;
endmodule

// File: rtl/qbus_dma_master.sv
// Qbus DMA master: one DATI/DATO per bus grant, with grant daisy-chain pass-through and timeout/BINIT abort.
module qbus_dma_master
  import qbus_pkg::*;
#(
  parameter int T_SETUP  = T_SETUP_DEF,
  parameter int T_HOLD   = T_HOLD_DEF,
  parameter int T_DESKEW = T_DESKEW_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input logic              clock,
  input logic              RSTN,
  qbus_dma_master_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + T_HOLD + T_SETUP + T_DESKEW + 1);
  localparam logic [CW-1:0] SETUP_LAST  = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] HOLD_N      = CW'(T_HOLD);
  localparam logic [CW-1:0] DATO_LAST   = CW'(T_HOLD + T_SETUP - 1);
  localparam logic [CW-1:0] DATI_LAST   = CW'(T_HOLD);
  localparam logic [CW-1:0] DESKEW_LAST = CW'(T_DESKEW - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX     = '1;

  // Bus receivers are active low; everything past the synchronizer is true = asserted.
  logic [3:0]  ctl_s;
  logic [15:0] bdal_s;
  logic        sBRPLY, sBDMGI, sBSYNC, sBINIT;
  logic        unused_bdal;

  qbus_sync #(.W(4), .RST_VAL(1'b1)) u_sync_ctl (
    .clock(clock), .RSTN(RSTN),
    .d({bus.BINITf, bus.BSYNCf, bus.BDMGIf, bus.BRPLYf}), .q(ctl_s)
  );
  qbus_sync #(.W(16), .RST_VAL(1'b1)) u_sync_bdal (
    .clock(clock), .RSTN(RSTN), .d(bus.BDALf_IN[15:0]), .q(bdal_s)
  );

  assign {sBINIT, sBSYNC, sBDMGI, sBRPLY} = ~ctl_s;
  assign unused_bdal = ^bus.BDALf_IN[21:16];

  qstate_e       state_q, state_d;
  logic [CW-1:0] cnt_q;
  qcmd_t         cmd_q;
  logic          err_q, rply_q;
  logic [15:0]   rdata_q;
  logic          accept, abort, cnt_clr, rply_set, cap, tmo;

  assign accept = (state_q == S_IDLE) && bus.cmd_valid && !sBINIT;
  assign tmo    = (cnt_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    abort    = 1'b0;
    cnt_clr  = 1'b0;
    rply_set = 1'b0;
    cap      = 1'b0;
    unique case (state_q)
      S_IDLE:    if (accept) state_d = S_REQ;
      S_REQ:     if (sBDMGI) state_d = S_WAITBUS; else if (tmo) abort = 1'b1;
      S_WAITBUS: if (!sBSYNC && !sBRPLY) state_d = S_ADDR;
      S_ADDR:    if (cnt_q == SETUP_LAST) state_d = S_ASYNC;
      S_ASYNC:   if (cnt_q == (cmd_q.write ? DATO_LAST : DATI_LAST)) state_d = S_DATA;
      S_DATA: begin
        // DATI keeps BDIN up for the deskew window after reply, then latches the bus.
        if (rply_q) begin
          if (cnt_q == DESKEW_LAST) begin
            cap     = 1'b1;
            state_d = S_WREPLY;
          end
        end else if (sBRPLY) begin
          if (cmd_q.write) state_d = S_WREPLY;
          else begin
            rply_set = 1'b1;
            cnt_clr  = 1'b1;
          end
        end else if (tmo) abort = 1'b1;
      end
      S_WREPLY:  if (!sBRPLY) state_d = S_WEND; else if (tmo) abort = 1'b1;
      S_WEND:    state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (sBINIT && state_q != S_IDLE && state_q != S_DONE) abort = 1'b1;
    if (abort) state_d = S_DONE;
  end

  always_ff @(posedge clock or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      err_q   <= 1'b0;
      rply_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || cnt_clr) cnt_q <= '0;
      else if (cnt_q != CNT_MAX)         cnt_q <= cnt_q + CW'(1);
      if (accept) begin
        cmd_q <= '{write: bus.cmd_write, bmode: bus.cmd_byte,
                   addr: bus.cmd_addr, wdata: bus.cmd_wdata};
        err_q <= 1'b0;
      end
      if (abort) err_q <= 1'b1;
      rply_q <= (state_d == S_DATA) && (rply_q || rply_set);
      if (cap) rdata_q <= ~bdal_s;
    end
  end

  // Bus drives decode from state only, so async reset or an abort drops every line together.
  logic drv_addr, drv_data;
  logic g_sync, g_din, g_dout, g_wtbt, g_bs7, g_dmr, g_sack;

  always_comb begin
    drv_addr = 1'b0;
    drv_data = 1'b0;
    g_sync   = 1'b0;
    g_din    = 1'b0;
    g_dout   = 1'b0;
    g_wtbt   = 1'b0;
    g_bs7    = 1'b0;
    g_dmr    = 1'b0;
    g_sack   = 1'b0;
    unique case (state_q)
      S_REQ, S_WAITBUS: g_dmr = 1'b1;
      S_ADDR: begin
        g_sack   = 1'b1;
        drv_addr = 1'b1;
        g_bs7    = is_iopage(cmd_q.addr);
        g_wtbt   = cmd_q.write;
      end
      S_ASYNC: begin
        g_sack = 1'b1;
        g_sync = 1'b1;
        g_wtbt = cmd_q.write & cmd_q.bmode;
        if (cnt_q < HOLD_N) drv_addr = 1'b1;
        else                drv_data = cmd_q.write;
      end
      S_DATA: begin
        g_sack   = 1'b1;
        g_sync   = 1'b1;
        g_wtbt   = cmd_q.write & cmd_q.bmode;
        drv_data = cmd_q.write;
        g_din    = !cmd_q.write;
        g_dout   = cmd_q.write;
      end
      S_WREPLY: begin
        g_sack   = 1'b1;
        g_sync   = 1'b1;
        g_wtbt   = cmd_q.write & cmd_q.bmode;
        drv_data = cmd_q.write;
      end
      default: ;
    endcase
  end

  assign bus.BDALf_OUT = drv_addr ? cmd_q.addr : (drv_data ? {6'b0, cmd_q.wdata} : '0);
  assign bus.BDALf_OE  = {22{drv_addr | drv_data}};
  assign bus.Outbound  = drv_addr | drv_data;
  assign bus.BSYNCg    = g_sync;
  assign bus.BDINg     = g_din;
  assign bus.BDOUTg    = g_dout;
  assign bus.BWTBTg    = g_wtbt;
  assign bus.BBS7g     = g_bs7;
  assign bus.BDMRg     = g_dmr;
  assign bus.BSACKg    = g_sack;
  assign bus.BDMGOg    = sBDMGI && (state_q == S_IDLE);

  assign bus.cmd_ready = (state_q == S_IDLE) && !sBINIT;
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rsp_error = (state_q == S_DONE) && err_q;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_qbus_dma_master.sv
// Scoreboarded bench: arbiter + memory slave models on the bus, reference memory for expected responses.
module tb_qbus_dma_master;
  logic clock = 1'b0;
  logic RSTN  = 1'b0;
  always #5 clock = ~clock;

  qbus_dma_master_if bus();
  qbus_dma_master dut (.clock(clock), .RSTN(RSTN), .bus(bus));

  typedef struct { logic err; logic chk; logic [15:0] data; } exp_t;
  exp_t        exp_q[$];
  logic [15:0] rmem [logic [21:0]];
  logic [15:0] smem [logic [21:0]];

  int   total = 0, bad = 0, rsp_cnt = 0, leak = 0, rply_dly = 0, arb_dly = 0;
  logic slv_en = 1'b1, gnt_force = 1'b0, gnt_arb = 1'b0, sync_d = 1'b0;
  logic [21:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        lat_bs7, lat_wtbt_a, lat_wtbt_d;
  localparam logic [21:0] IOBASE = 22'o17760000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic logic [31:0] lines();
    return 32'({bus.BSYNCg, bus.BDINg, bus.BDOUTg, bus.BWTBTg, bus.BBS7g, bus.BDMRg,
                bus.BSACKg, bus.BDMGOg, bus.Outbound, |bus.BDALf_OE, |bus.BDALf_OUT});
  endfunction

  // Arbiter: grants some clocks after BDMR, withdraws once BSACK shows up.
  initial begin
    bus.BDMGIf = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (!RSTN) gnt_arb = 1'b0;
      else if (!gnt_arb && bus.BDMRg && !bus.BSACKg) begin
        if (arb_dly == 0) gnt_arb = 1'b1; else arb_dly--;
      end else if (gnt_arb && (bus.BSACKg || !bus.BDMRg)) begin
        gnt_arb = 1'b0;
        arb_dly = $urandom_range(0, 4);
      end
      bus.BDMGIf = !(gnt_arb || gnt_force);
    end
  end

  // Memory slave: latches address at BSYNC, replies after rply_dly clocks.
  initial begin
    logic [15:0] w;
    int rcnt;
    rcnt = 0;
    bus.BRPLYf = 1'b1;
    bus.BDALf_IN = '1;
    forever begin
      @(posedge clock); #1;
      if (!RSTN) begin
        bus.BRPLYf = 1'b1; bus.BDALf_IN = '1; sync_d = 1'b0; rcnt = 0;
        continue;
      end
      if (bus.Outbound && bus.BSACKg && !bus.BSYNCg) begin
        lat_bs7 = bus.BBS7g; lat_wtbt_a = bus.BWTBTg;
      end
      if (bus.BSYNCg && !sync_d) lat_addr = bus.BDALf_OUT;
      sync_d = bus.BSYNCg;
      if (bus.BRPLYf) begin
        if (slv_en && bus.BSYNCg && (bus.BDINg || bus.BDOUTg)) begin
          if (rcnt < rply_dly) rcnt++;
          else begin
            rcnt = 0;
            w = smem.exists({lat_addr[21:1], 1'b0}) ? smem[{lat_addr[21:1], 1'b0}] : 16'h0;
            if (bus.BDINg) bus.BDALf_IN = ~{6'b0, w};
            else begin
              lat_wdata = bus.BDALf_OUT[15:0]; lat_wtbt_d = bus.BWTBTg;
              if (!bus.BWTBTg)    w = lat_wdata;
              else if (lat_addr[0]) w[15:8] = lat_wdata[15:8];
              else                w[7:0]  = lat_wdata[7:0];
              smem[{lat_addr[21:1], 1'b0}] = w;
            end
            bus.BRPLYf = 1'b0;
          end
        end
      end else if (!bus.BDINg && !bus.BDOUTg) begin
        bus.BRPLYf = 1'b1; bus.BDALf_IN = '1;
      end
    end
  end

  // Monitor: pops one expectation per rsp_valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (RSTN && bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexpected: got response with nothing expected");
        end else begin
          e = exp_q.pop_front();
          chk("rsp_error", 32'(bus.rsp_error), 32'(e.err));
          if (e.chk) chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.data));
          chk("rsp_bus_idle", lines(), 32'(0));
        end
        rsp_cnt++;
      end
      if (RSTN && !bus.cmd_ready && bus.BDMGOg) leak++;
    end
  end

  task automatic issue(input logic w, input logic b, input logic [21:0] a,
                       input logic [15:0] d, input logic err);
    exp_t e;
    logic [21:0] wa;
    logic [15:0] old;
    int n;
    wa  = {a[21:1], 1'b0};
    old = rmem.exists(wa) ? rmem[wa] : 16'h0;
    e.err = err; e.chk = !w && !err; e.data = old;
    if (w && !err) begin
      if (!b)       old = d;
      else if (a[0]) old[15:8] = d[15:8];
      else          old[7:0]  = d[7:0];
      rmem[wa] = old;
    end
    exp_q.push_back(e);
    @(negedge clock);
    n = 0;
    while (!bus.cmd_ready && n < 50) begin @(negedge clock); n++; end
    chk("cmd_ready", 32'(bus.cmd_ready), 32'(1));
    bus.cmd_write = w; bus.cmd_byte = b; bus.cmd_addr = a; bus.cmd_wdata = d;
    bus.cmd_valid = 1'b1;
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom); bus.cmd_byte = 1'($urandom);
    bus.cmd_addr = 22'($urandom); bus.cmd_wdata = 16'($urandom);
  endtask

  task automatic wait_rsp(input int n0);
    int i;
    i = 0;
    while (rsp_cnt == n0 && i < 3000) begin @(negedge clock); i++; end
    chk("rsp_arrived", 32'(rsp_cnt != n0), 32'(1));
  endtask

  task automatic xfer(input logic w, input logic b, input logic [21:0] a,
                      input logic [15:0] d, input logic err);
    int n0;
    logic [21:0] wa;
    wa = {a[21:1], 1'b0};
    lat_addr = 'x; lat_bs7 = 1'bx; lat_wtbt_a = 1'bx; lat_wtbt_d = 1'bx; lat_wdata = 'x;
    n0 = rsp_cnt;
    issue(w, b, a, d, err);
    wait_rsp(n0);
    if (!err) begin
      chk("addr_on_bus", 32'(lat_addr), 32'(a));
      chk("bbs7_addr", 32'(lat_bs7), 32'(a >= IOBASE));
      chk("bwtbt_addr", 32'(lat_wtbt_a), 32'(w));
      if (w) begin
        chk("wdata_on_bus", 32'(lat_wdata), 32'(d));
        chk("bwtbt_data", 32'(lat_wtbt_d), 32'(b));
        chk("slave_mem", 32'(smem.exists(wa) ? smem[wa] : 16'h0), 32'(rmem[wa]));
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_byte = 1'b0;
    bus.cmd_addr = '0; bus.cmd_wdata = '0; bus.BINITf = 1'b1; bus.BSYNCf = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'(1));
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'(0));
    chk("rst_bus_lines", lines(), 32'(0));
    RSTN = 1'b1;

    // grant passes down the chain while idle
    gnt_force = 1'b1;
    repeat (4) @(negedge clock);
    chk("bdmgo_pass", 32'(bus.BDMGOg), 32'(1));
    gnt_force = 1'b0;
    repeat (4) @(negedge clock);
    chk("bdmgo_release", 32'(bus.BDMGOg), 32'(0));

    rmem[22'o17772150] = 16'o123456;
    smem[22'o17772150] = 16'o123456;
    xfer(1'b0, 1'b0, 22'o17772150, 16'h0000, 1'b0);
    xfer(1'b1, 1'b0, 22'o00000100, 16'hA55A, 1'b0);
    xfer(1'b1, 1'b1, 22'o00000101, 16'h3400, 1'b0);
    chk("byte_high_only", 32'(smem[22'o100]), 32'(16'h345A));
    xfer(1'b0, 1'b0, 22'o00000100, 16'h0000, 1'b0);

    for (int k = 0; k < 40; k++) begin
      logic w, b;
      logic [21:0] a;
      logic [15:0] d;
      w = 1'($urandom_range(0, 1));
      b = w & 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) != 0) ? 22'o17772000 : 22'o00000100;
      a = a + 22'(2 * $urandom_range(0, 7));
      if (b) a[0] = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      rply_dly = $urandom_range(0, 3);
      xfer(w, b, a, d, 1'b0);
    end
    rply_dly = 0;

    // no reply: timeout, then the next command still goes through
    slv_en = 1'b0;
    xfer(1'b0, 1'b0, 22'o00000200, 16'h0, 1'b1);
    slv_en = 1'b1;
    xfer(1'b0, 1'b0, 22'o00000102, 16'h0, 1'b0);

    // BINIT during the data phase
    slv_en = 1'b0;
    issue(1'b0, 1'b0, 22'o00000104, 16'h0, 1'b1);
    i = 0;
    while (!bus.BDINg && i < 100) begin @(negedge clock); i++; end
    chk("bdin_before_binit", 32'(bus.BDINg), 32'(1));
    bus.BINITf = 1'b0;
    repeat (3) @(negedge clock);
    chk("binit_bus_lines", lines(), 32'(0));
    repeat (2) @(negedge clock);
    chk("binit_holds_cmd", 32'(bus.cmd_ready), 32'(0));
    chk("binit_rsp_seen", 32'(exp_q.size()), 32'(0));
    bus.BINITf = 1'b1;
    repeat (3) @(negedge clock);
    chk("binit_release_ready", 32'(bus.cmd_ready), 32'(1));
    slv_en = 1'b1;

    // reset in the middle of the address/sync phase
    issue(1'b0, 1'b0, 22'o00000106, 16'h0, 1'b0);
    i = 0;
    while (!bus.BSYNCg && i < 100) begin @(negedge clock); i++; end
    chk("bsync_before_reset", 32'(bus.BSYNCg), 32'(1));
    RSTN = 1'b0;
    #1;
    chk("async_rst_lines", lines(), 32'(0));
    chk("async_rst_ready", 32'(bus.cmd_ready), 32'(1));
    chk("async_rst_rsp", 32'(bus.rsp_valid), 32'(0));
    exp_q.delete();
    repeat (2) @(negedge clock);
    RSTN = 1'b1;
    xfer(1'b0, 1'b0, 22'o00000100, 16'h0, 1'b0);

    repeat (5) @(negedge clock);
    chk("grant_never_passed_busy", 32'(leak), 32'(0));
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
